uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

UART receiver for the board's USB-serial line: deserialises 8N1 frames arriving on `usb_rx` into bytes and presents them on a valid/ready output for downstream logic such as LED display, command decode or a loopback transmitter. It sits directly behind the top-level `usb_rx` pin, in the single `clk` domain. It flags framing errors and overruns.

## Interface
- `CLK_HZ`, default 100_000_000 — system clock frequency in Hz.
- `BAUD`, default 115200 — line rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, 868 at defaults), must be ≥ 4.
- `clk  input  1` — system clock; all logic on rising edge.
- `rst_n  input  1` — reset, synchronous, active-low.
- `rx  input  1` — asynchronous serial line (idle high), from `usb_rx`.
- `data  output  8` — received byte, stable while `valid` is high.
- `valid  output  1` — byte available; held until accepted.
- `ready  input  1` — consumer accepts `data` on a cycle where `valid && ready`.
- `frame_err  output  1` — one-cycle pulse: stop bit sampled low.
- `overrun  output  1` — one-cycle pulse: a byte completed while `valid` was still high.
- `parity_err  output  1` — one-cycle pulse: parity mismatch. Constant 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- `rx` passes through a 2-flop synchroniser; the synchroniser resets to 1. All decisions use the synchronised value `rx_s`.
- States:
  - IDLE: on `rx_s == 0`, go to START and load the bit counter with `CLKS_PER_BIT/2 - 1`.
  - START: at counter expiry, re-sample `rx_s`.
    - If 1: false start; return to IDLE with no flags.
    - If 0: go to DATA with bit index 0 and counter `CLKS_PER_BIT - 1`.
  - DATA: at each expiry, shift `rx_s` in LSB first. After bit 7, go to PARITY (if enabled) else STOP.
  - PARITY: sample one bit. It must equal the XOR of the 8 data bits (even parity).
  - STOP: sample the stop bit.
    - If 1: commit the byte.
    - If 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE (prevents a held-low line from retriggering).
- Commit rules:
  - If `valid == 0`, or `valid && ready` in the same cycle: load `data`, assert `valid`.
  - If `valid && !ready`: drop the new byte, keep the old one, pulse `overrun`.
- A parity mismatch pulses `parity_err` and discards the byte. The stop bit is still checked, and `frame_err` may pulse in the same frame.
- `valid` clears on the cycle after a `valid && ready` handshake, unless a commit happens in that same cycle.

## Timing
- Reset values: `data = 0x00`, `valid = 0`, `frame_err = 0`, `overrun = 0`, `parity_err = 0`, state IDLE, synchroniser = 1.
- Reset mid-frame aborts the frame immediately; no flags are produced.
- Pin-to-detect latency: 2 cycles (synchroniser) plus 1 cycle (IDLE sees 0).
- Stop-bit sample point, counted from the IDLE detect cycle:
  - `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles without parity.
  - `+ CLKS_PER_BIT` with parity.
- `valid` and the flag pulses assert the cycle after the stop sample.
- The receiver returns to IDLE in the same cycle as the commit, so back-to-back frames with 1 stop bit are received without loss.
- `ready` has no effect when `valid == 0`. There is no combinational path from `ready` to `valid`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 8E1: 11 bits per frame.
  - The PARITY state exists.
  - `parity_err` is live.
- Not defined:
  - Frames are 8N1.
  - The PARITY state is absent.
  - `parity_err` is tied to 0; the port remains in both builds.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `UART_DATA_W = 8`;
  - a function computing `CLKS_PER_BIT` from `CLK_HZ` and `BAUD`.
- One sub-module, `sync_2ff`: generic 2-flop synchroniser with a parameterised reset value. It is reused for other asynchronous inputs.

## Test plan
Benches use `CLK_HZ = 1_000_000`, `BAUD = 100_000`, so `CLKS_PER_BIT = 10`.
- Single frame 0xA5, `ready` held high: `valid` pulses for one cycle with `data = 0xA5`; no flags.
- Frames 0x3C and 0xC3 back-to-back, `ready` low until both complete:
  - `data` stays 0x3C with `valid` high;
  - `overrun` pulses once when the second frame completes.
- Frame 0x55 with the stop bit driven low: `frame_err` pulses, `valid` stays 0, the FSM stays in BREAK until `rx` returns high, and a following 0x12 is received correctly.
- Glitch: `rx` low for 3 cycles only: no `valid` and no flags; the FSM is back in IDLE 5 cycles after detect.
- Reset asserted for 1 cycle midway through data bit 4 of frame 0xFF: all outputs read 0 and no byte is produced. A frame sent after the line has idled high is then received correctly.
- `UART_RX_PARITY_EN` defined: frame 0x07 with parity 1 gives `data = 0x07`. The same frame with parity 0 pulses `parity_err`, and `valid` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with valid/ready output, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | half-bit wait, confirm start bit is still low
// DATA   | sample 8 data bits at bit centres, LSB first
// PARITY | sample even-parity bit (parity builds only)
// STOP   | sample stop bit, commit byte or flag framing error
// BREAK  | line held low after a bad stop bit, wait for high
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

    logic rx_s;

    state_e                 state_d, state_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic [2:0]             bit_idx_d, bit_idx_q;
    logic [UART_DATA_W-1:0] shift_d, shift_q;
    logic [UART_DATA_W-1:0] data_d, data_q;
    logic                   valid_d, valid_q;
    logic                   frame_err_d, frame_err_q;
    logic                   overrun_d, overrun_q;
    logic                   tc;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_d, par_bad_q;
    logic                   parity_err_d, parity_err_q;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign tc = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q && !ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (!tc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    cnt_d     = CNT_FULL;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (!tc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
                    cnt_d     = CNT_FULL;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!tc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    par_bad_d = (rx_s != ^shift_q);
                    cnt_d     = CNT_FULL;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!tc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad_q;
`endif
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end else begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (!par_bad_q) begin
`else
                        begin
`endif
                            if (!valid_q || ready) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 10 clocks per bit.
module tb_uart_rx_byte;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_pass  = 0;
    int n_total = 0;

    int valid_cycles = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] last_data = 8'h00;
    int v0, f0, o0, p0;

`ifdef UART_RX_PARITY_EN
    logic bad_par = 1'b0;
`endif

    uart_rx_byte #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Pulse/level accounting, sampled on the falling edge.
    always @(negedge clk) begin
        valid_cycles <= valid_cycles + int'(valid);
        fe_cnt       <= fe_cnt + int'(frame_err);
        ov_cnt       <= ov_cnt + int'(overrun);
        pe_cnt       <= pe_cnt + int'(parity_err);
        if (valid) last_data <= data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic snap();
        v0 = valid_cycles;
        f0 = fe_cnt;
        o0 = ov_cnt;
        p0 = pe_cnt;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_par;
        repeat (10) tick();
`endif
        rx = stop_bit;
        repeat (10) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) tick();
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        rst_n = 1'b1;
        idle(10);

        // single frame, ready held high
        ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("a5_data", 32'(last_data), 32'hA5);
        check("a5_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("a5_overrun", 32'(ov_cnt - o0), 32'd0);

        // back-to-back frames with ready low
        ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(20);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_data", 32'(data), 32'h3C);
        check("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
        check("ovr_frame_err", 32'(fe_cnt - f0), 32'd0);
        ready = 1'b1;
        tick();
        check("handshake_clears_valid", 32'(valid), 32'h0);
        check("handshake_keeps_data", 32'(data), 32'h3C);

        // bad stop bit, line held low afterwards
        idle(10);
        snap();
        send_frame(8'h55, 1'b0);
        repeat (30) tick();
        check("fe_pulses", 32'(fe_cnt - f0), 32'd1);
        check("fe_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("fe_in_break", 32'(dut.state_q), 32'(ST_BREAK));
        idle(20);
        check("fe_back_idle", 32'(dut.state_q), 32'(ST_IDLE));
        snap();
        send_frame(8'h12, 1'b1);
        idle(20);
        check("after_fe_data", 32'(last_data), 32'h12);
        check("after_fe_valid_cycles", 32'(valid_cycles - v0), 32'd1);

        // three-cycle glitch
        snap();
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        check("glitch_detect", 32'(dut.state_q), 32'(ST_START));
        repeat (4) tick();
        check("glitch_still_start", 32'(dut.state_q), 32'(ST_START));
        tick();
        check("glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));
        idle(20);
        check("glitch_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("glitch_no_flags", 32'((fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0)), 32'd0);

        // reset mid data bit 4 of 0xFF, with a byte pending
        ready = 1'b0;
        send_frame(8'h6E, 1'b1);
        idle(5);
        check("pre_rst_valid", 32'(valid), 32'h1);
        rx = 1'b0;
        repeat (10) tick();
        rx = 1'b1;
        repeat (45) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_flags", 32'({frame_err, overrun, parity_err}), 32'h0);
        rst_n = 1'b1;
        ready = 1'b1;
        snap();
        idle(60);
        check("midrst_no_byte", 32'(valid_cycles - v0), 32'd0);
        check("midrst_no_flags", 32'((fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0)), 32'd0);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("post_rst_data", 32'(last_data), 32'h81);
        check("post_rst_valid_cycles", 32'(valid_cycles - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
        snap();
        bad_par = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(20);
        check("par_ok_data", 32'(last_data), 32'h07);
        check("par_ok_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("par_ok_no_err", 32'(pe_cnt - p0), 32'd0);
        snap();
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(20);
        check("par_bad_err", 32'(pe_cnt - p0), 32'd1);
        check("par_bad_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("par_bad_no_fe", 32'(fe_cnt - f0), 32'd0);
`else
        check("parity_err_never", 32'(pe_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
